rgb_frame_sequencer: RTL
========================

Name: rgb_frame_sequencer

Overview:
Controls the RGB capture datapath. It takes the registered pixel stream (pixel_valid/pixel_data) and the raw vsync, and writes complete frames into a two-bank (ping-pong) framebuffer. It performs the front/back bank swap handshake with the display consumer. It drops frames the consumer has no room for, and flags malformed frames. It also drives the datapath's rgb_enable.

Parameters:
FRAME_PIXELS, 2560, pixels per valid frame (40 x 64).
IDX_W, 12, width of the in-bank pixel index. Requires 2^IDX_W >= FRAME_PIXELS.

Ports:
rgb_clk  in  1  pixel clock
nrst  in  1  reset, asynchronous, active-low
capture_enable  in  1  level, capture allowed (SPI config)
vsync  in  1  raw vsync, same cycle as the datapath input
pixel_valid  in  1  registered valid from the capture datapath (1 cycle behind hsync&vsync)
pixel_data  in  24  registered RGB from the datapath
rgb_enable  out  1  to datapath, 1 while in CAPTURE
wr_en  out  1  framebuffer write strobe
wr_addr  out  IDX_W+1  {bank, index}
wr_data  out  24  write data
front_bank  out  1  bank the consumer reads
frame_pending  out  1  back bank holds a complete, unswapped frame
swap_ack  in  1  1-cycle pulse from the consumer: safe to swap
err_clear  in  1  1-cycle pulse, clears error flags and the drop counter
err_short  out  1  sticky, a frame ended before FRAME_PIXELS
err_long  out  1  sticky, a frame had more than FRAME_PIXELS pixels
frames_dropped  out  8  saturating count of skipped frames

Behaviour:
- Reset values: every output is 0; state IDLE; index 0; internal vsync_r is 0.
- Edge detection:
  - vs_rise = ~vsync_r & vsync.
  - vs_fall = vsync_r & ~vsync.
  - vsync_r is vsync registered once.
- States:
  - IDLE: capture_enable=1 -> WAIT_VS.
  - WAIT_VS, on vs_rise, evaluated after any same-cycle swap:
    - frame_pending=0 -> CAPTURE, index reset to 0.
    - frame_pending=1 -> SKIP, frames_dropped +1, saturating at 255.
  - CAPTURE: each pixel_valid writes at the current index, then index +1.
    - When the write of index FRAME_PIXELS-1 is issued: set frame_pending (visible the next cycle) -> WAIT_END.
    - vs_fall with the total count (including a pixel_valid in the same cycle) < FRAME_PIXELS: err_short=1, partial frame discarded, frame_pending unchanged -> WAIT_VS.
  - WAIT_END: any pixel_valid is ignored and sets err_long=1. vs_fall -> WAIT_VS.
  - SKIP: no writes. vs_fall -> WAIT_VS.
- Write port, 1-cycle registered latency:
  - wr_en = pixel_valid & CAPTURE.
  - wr_addr = {~front_bank, index}.
  - wr_data = pixel_data.
  - wr_en is 0 in every other state.
- Swap: swap_ack & frame_pending -> front_bank toggles and frame_pending clears in the next cycle. swap_ack with frame_pending=0 is ignored.
- Simultaneous events:
  - Frame completion and swap_ack in the same cycle: the swap sees the old frame_pending (0), so no swap.
  - swap_ack and vs_rise in the same cycle with pending=1: the swap wins, and the frame is captured into the newly freed bank (the old front).
- capture_enable falling in any state -> IDLE next cycle. A frame in progress is discarded; frame_pending and front_bank are kept. The swap handshake stays active in IDLE.
- rgb_enable = (state==CAPTURE).
- err_clear clears err_short, err_long and frames_dropped. A new error in the same cycle wins, so the flag stays 1.
- Asynchronous nrst mid-frame: immediate return to the reset values above; the next capture starts at the next vs_rise.

Test Plan:
- Full frame:
  - Stimulus: front_bank=0, enable; vsync high with 2560 valid pixels.
  - Response: 2560 wr_en pulses, wr_addr 0x1000..0x19FF in order; frame_pending=1 after the last write; rgb_enable=0 afterwards.
- Swap:
  - Stimulus: swap_ack pulse after the full frame.
  - Response: front_bank=1, frame_pending=0; the next frame writes 0x0000..0x09FF.
- Drop:
  - Stimulus: a second frame with no swap_ack.
  - Response: no wr_en; frames_dropped=1; after 256 drops it reads 255.
- Short frame:
  - Stimulus: vsync falls after 100 pixels.
  - Response: err_short=1, frame_pending=0; the next frame starts at index 0; err_clear returns err_short to 0.
- Long frame:
  - Stimulus: 2565 pixels.
  - Response: exactly 2560 writes, err_long=1, frame_pending=1.
- Corner cases:
  - swap_ack coincident with vs_rise while pending=1 -> captured, not dropped.
  - nrst low at pixel 1000 -> all outputs 0; the next full frame captures cleanly into bank 1.

Source files
------------

// File: rtl/rgb_frame_sequencer.sv
// Frame sequencer for the RGB capture path: writes whole frames into a ping-pong
// framebuffer, runs the bank swap handshake, drops frames with no free bank, flags bad frames.
module rgb_frame_sequencer #(
  parameter int FRAME_PIXELS = 2560,
  parameter int IDX_W        = 12
) (
  input  logic             rgb_clk,
  input  logic             nrst,
  input  logic             capture_enable,
  input  logic             vsync,
  input  logic             pixel_valid,
  input  logic [23:0]      pixel_data,
  output logic             rgb_enable,
  output logic             wr_en,
  output logic [IDX_W:0]   wr_addr,
  output logic [23:0]      wr_data,
  output logic             front_bank,
  output logic             frame_pending,
  input  logic             swap_ack,
  input  logic             err_clear,
  output logic             err_short,
  output logic             err_long,
  output logic [7:0]       frames_dropped
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VS  = 3'd1,
    CAPTURE  = 3'd2,
    WAIT_END = 3'd3,
    SKIP     = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  state_t           state_r;
  logic [IDX_W-1:0] index_r;
  logic             vsync_r;
  logic             vs_rise_s;
  logic             vs_fall_s;
  logic             swap_s;
  logic             last_px_s;
  logic [7:0]       drop_inc_s;

  assign vs_rise_s  = ~vsync_r & vsync;
  assign vs_fall_s  = vsync_r & ~vsync;
  assign swap_s     = swap_ack & frame_pending;
  assign last_px_s  = pixel_valid & (index_r == LAST_IDX);
  // A drop coinciding with err_clear restarts the count at one rather than zero.
  assign drop_inc_s = err_clear ? 8'd1 :
                      (frames_dropped == 8'hFF) ? 8'hFF : frames_dropped + 8'd1;

  // Sequencer state, write port, bank swap and error bookkeeping.
  always_ff @(posedge rgb_clk or negedge nrst) begin
    if (!nrst) begin
      state_r        <= IDLE;
      index_r        <= '0;
      vsync_r        <= 1'b0;
      rgb_enable     <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= 24'd0;
      front_bank     <= 1'b0;
      frame_pending  <= 1'b0;
      err_short      <= 1'b0;
      err_long       <= 1'b0;
      frames_dropped <= 8'd0;
    end else begin
      vsync_r <= vsync;
      wr_en   <= pixel_valid & (state_r == CAPTURE);
      wr_addr <= {~front_bank, index_r};
      wr_data <= pixel_data;

      if (swap_s) begin
        front_bank    <= ~front_bank;
        frame_pending <= 1'b0;
      end

      // Later assignments below let a same-cycle error override the clear.
      if (err_clear) begin
        err_short      <= 1'b0;
        err_long       <= 1'b0;
        frames_dropped <= 8'd0;
      end

      if (!capture_enable) begin
        state_r    <= IDLE;
        rgb_enable <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= WAIT_VS;
          end
          WAIT_VS: begin
            if (vs_rise_s) begin
              // A swap in this same cycle frees the back bank before we decide.
              if (frame_pending && !swap_ack) begin
                state_r        <= SKIP;
                frames_dropped <= drop_inc_s;
              end else begin
                state_r    <= CAPTURE;
                rgb_enable <= 1'b1;
                index_r    <= '0;
              end
            end
          end
          CAPTURE: begin
            if (pixel_valid) begin
              index_r <= index_r + IDX_W'(1);
            end
            if (last_px_s) begin
              frame_pending <= 1'b1;
              rgb_enable    <= 1'b0;
              state_r       <= vs_fall_s ? WAIT_VS : WAIT_END;
            end else if (vs_fall_s) begin
              err_short  <= 1'b1;
              rgb_enable <= 1'b0;
              state_r    <= WAIT_VS;
            end
          end
          WAIT_END: begin
            if (pixel_valid) begin
              err_long <= 1'b1;
            end
            if (vs_fall_s) begin
              state_r <= WAIT_VS;
            end
          end
          SKIP: begin
            if (vs_fall_s) begin
              state_r <= WAIT_VS;
            end
          end
          default: begin
            state_r    <= IDLE;
            rgb_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
